// File: rtl/system86_mem_pkg.sv
// Shared definitions for the System86 memory-interface sequencers:
// state encoding and an elaboration-time ceiling-log2 helper.
`timescale 1ns/1ps
package system86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } seq_state_t;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rom_read_sequencer.sv
// Cycle-counted read sequencer for a 27128-class asynchronous EPROM: holds E/G
// low for the access window, captures Q, then holds E/G high for recovery.
`timescale 1ns/1ps
module rom_read_sequencer
    import system86_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 8,
    parameter int ACCESS_CYCLES   = 13,
    parameter int RECOVERY_CYCLES = 3
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    output logic                  REQ_READY,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  ROM_E,
    output logic                  ROM_G,
    output logic [ADDR_WIDTH-1:0] ROM_A,
    input  logic [DATA_WIDTH-1:0] ROM_Q
);

    localparam int CNT_MAX_A = (ACCESS_CYCLES > 2) ? ACCESS_CYCLES : 2;
    localparam int CNT_MAX   = (RECOVERY_CYCLES > CNT_MAX_A) ? RECOVERY_CYCLES : CNT_MAX_A;
    localparam int CNT_W     = clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

    if (ACCESS_CYCLES < 1) begin : g_bad_access
        $error("rom_read_sequencer: ACCESS_CYCLES must be at least 1");
    end

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Combinational so a request can be accepted in the first IDLE cycle.
    assign REQ_READY = RST_n && (state == IDLE);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ROM_E     <= 1'b1;
            ROM_G     <= 1'b1;
            ROM_A     <= '0;
            RSP_DATA  <= '0;
            RSP_VALID <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        ROM_A <= REQ_ADDR;
                        ROM_E <= 1'b0;
                        ROM_G <= 1'b0;
                        cnt   <= ACC_LOAD;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Q has been stable for the full access window on this edge.
                        RSP_DATA  <= ROM_Q;
                        RSP_VALID <= 1'b1;
                        ROM_E     <= 1'b1;
                        ROM_G     <= 1'b1;
                        if (RECOVERY_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= REC_LOAD;
                            state <= RECOVER;
                        end
                    end
                end
                RECOVER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Directed bench for rom_read_sequencer: two instances (default timing and
// zero recovery), each driving a behavioural 27128 EPROM model.
`timescale 1ns/1ps
module tb_rom_read_sequencer;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid [2];
    logic [AW-1:0] req_addr  [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_data  [2];
    logic          rom_e     [2];
    logic          rom_g     [2];
    logic [AW-1:0] rom_a     [2];
    logic [DW-1:0] rom_q     [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_read_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(13), .RECOVERY_CYCLES(3)
    ) dut0 (
        .CLK(clk), .RST_n(rst_n),
        .REQ_VALID(req_valid[0]), .REQ_ADDR(req_addr[0]), .REQ_READY(req_ready[0]),
        .RSP_VALID(rsp_valid[0]), .RSP_DATA(rsp_data[0]),
        .ROM_E(rom_e[0]), .ROM_G(rom_g[0]), .ROM_A(rom_a[0]), .ROM_Q(rom_q[0])
    );

    rom_read_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(13), .RECOVERY_CYCLES(0)
    ) dut1 (
        .CLK(clk), .RST_n(rst_n),
        .REQ_VALID(req_valid[1]), .REQ_ADDR(req_addr[1]), .REQ_READY(req_ready[1]),
        .RSP_VALID(rsp_valid[1]), .RSP_DATA(rsp_data[1]),
        .ROM_E(rom_e[1]), .ROM_G(rom_g[1]), .ROM_A(rom_a[1]), .ROM_Q(rom_q[1])
    );

    function automatic logic [7:0] pattern(input logic [13:0] a);
        return a[7:0] ^ a[13:6];
    endfunction

    // EPROM model: data valid 250 ns after the last A/E/G change while
    // selected, complemented garbage before that, floats 60 ns after deselect.
    for (genvar g = 0; g < 2; g++) begin : g_dev
        time  t_sel = 0;
        logic [7:0] q = 8'h00;
        int   rsp_cnt = 0;
        int   eg_split = 0;
        time  t_fall = 0;
        time  t_rise = 0;
        time  low_time = 0;
        time  min_gap = 64'd1000000;
        bit   have_rise = 1'b0;

        assign rom_q[g] = q;

        always @(rom_a[g] or rom_e[g] or rom_g[g]) t_sel = $time;

        always begin
            #1;
            if (rom_e[g] == 1'b0 && rom_g[g] == 1'b0)
                q = (($time - t_sel) >= 250) ? pattern(rom_a[g]) : ~pattern(rom_a[g]);
            else if (($time - t_sel) >= 60)
                q = 8'hzz;
        end

        always @(negedge rom_e[g]) begin
            t_fall = $time;
            if (have_rise && ($time - t_rise) < min_gap) min_gap = $time - t_rise;
        end

        always @(posedge rom_e[g]) begin
            t_rise = $time;
            have_rise = 1'b1;
            low_time = $time - t_fall;
        end

        always @(negedge clk) begin
            if (rsp_valid[g]) rsp_cnt++;
            if (rom_e[g] !== rom_g[g]) eg_split++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic start(input int dv, input logic [13:0] a, input bit hold, output int acc_cyc);
        int n;
        n = 0;
        req_valid[dv] = 1'b1;
        req_addr[dv] = a;
        while (!req_ready[dv] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 100), 1);
        acc_cyc = cyc;
        @(negedge clk);
        if (!hold) req_valid[dv] = 1'b0;
    endtask

    task automatic wait_rsp(input int dv, output int lat, output logic [7:0] data);
        lat = 0;
        while (!rsp_valid[dv] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        data = rsp_data[dv];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            bad;
        int            n0;
        int            acc [3];
        logic [7:0]    d;
        logic [13:0]   b2b_addr [3];
        logic [7:0]    b2b_exp  [3];
        logic [13:0]   zr_addr  [3];
        logic [7:0]    zr_exp   [3];

        b2b_addr = '{14'h0000, 14'h3FFF, 14'h2AAA};
        b2b_exp  = '{8'h00, 8'h00, 8'h00};
        zr_addr  = '{14'h1234, 14'h3C0F, 14'h0155};
        zr_exp   = '{8'h7C, 8'hFF, 8'h50};

        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_addr[0] = '0;    req_addr[1] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rom_e", 32'(rom_e[0]), 1);
        chk("rst_rom_g", 32'(rom_g[0]), 1);
        chk("rst_rom_a", 32'(rom_a[0]), 0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
        chk("rst_rsp_data", 32'(rsp_data[0]), 0);
        chk("rst_req_ready", 32'(req_ready[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready[0]), 1);

        // Single read
        start(0, 14'h1234, 1'b0, acc[0]);
        chk("single_rom_a", 32'(rom_a[0]), 'h1234);
        wait_rsp(0, lat, d);
        chk("single_latency", 32'(lat), 13);
        chk("single_data", 32'(d), 'h7C);
        chk("single_eg_low_ns", 32'(g_dev[0].low_time), 260);
        @(negedge clk);
        chk("single_pulse_width", 32'(rsp_valid[0]), 0);
        chk("single_data_held", 32'(rsp_data[0]), 'h7C);
        repeat (5) @(negedge clk);

        // Back-to-back with REQ_VALID held high
        for (int i = 0; i < 3; i++) begin
            start(0, b2b_addr[i], 1'b1, acc[i]);
            wait_rsp(0, lat, d);
            chk("b2b_data", 32'(d), 32'(b2b_exp[i]));
            chk("b2b_latency", 32'(lat), 13);
        end
        req_valid[0] = 1'b0;
        chk("b2b_spacing_01", 32'(acc[1] - acc[0]), 17);
        chk("b2b_spacing_12", 32'(acc[2] - acc[1]), 17);
        chk("b2b_gap_ge_80ns", 32'(g_dev[0].min_gap >= 80), 1);
        repeat (6) @(negedge clk);

        // Address stability under a moving REQ_ADDR
        start(0, 14'h0ABC, 1'b0, acc[0]);
        lat = 0;
        bad = 0;
        while (!rsp_valid[0] && lat < 100) begin
            req_addr[0] = 14'(lat * 933 + 7);
            if (rom_a[0] !== 14'h0ABC) bad++;
            @(negedge clk);
            lat++;
        end
        chk("stab_rom_a_moves", 32'(bad), 0);
        chk("stab_latency", 32'(lat), 13);
        chk("stab_data", 32'(rsp_data[0]), 'h96);
        repeat (6) @(negedge clk);
        chk("stab_rom_a_held", 32'(rom_a[0]), 'h0ABC);
        chk("stab_rsp_data_held", 32'(rsp_data[0]), 'h96);

        // Reset in the middle of an access
        n0 = g_dev[0].rsp_cnt;
        start(0, 14'h3FFF, 1'b0, acc[0]);
        repeat (5) @(negedge clk);
        chk("abort_e_low_before", 32'(rom_e[0]), 0);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_rom_e", 32'(rom_e[0]), 1);
        chk("abort_rom_g", 32'(rom_g[0]), 1);
        chk("abort_rom_a", 32'(rom_a[0]), 0);
        chk("abort_rsp_data", 32'(rsp_data[0]), 0);
        chk("abort_req_ready", 32'(req_ready[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_response", 32'(g_dev[0].rsp_cnt), 32'(n0));
        start(0, 14'h0155, 1'b0, acc[0]);
        wait_rsp(0, lat, d);
        chk("after_abort_latency", 32'(lat), 13);
        chk("after_abort_data", 32'(d), 'h50);
        repeat (6) @(negedge clk);

        // Zero-recovery instance
        for (int i = 0; i < 3; i++) begin
            start(1, zr_addr[i], 1'b1, acc[i]);
            wait_rsp(1, lat, d);
            chk("zr_data", 32'(d), 32'(zr_exp[i]));
            chk("zr_latency", 32'(lat), 13);
        end
        req_valid[1] = 1'b0;
        chk("zr_spacing_01", 32'(acc[1] - acc[0]), 14);
        chk("zr_spacing_12", 32'(acc[2] - acc[1]), 14);
        chk("zr_gap_ns", 32'(g_dev[1].min_gap), 20);
        repeat (4) @(negedge clk);

        chk("eg_together_dut0", 32'(g_dev[0].eg_split), 0);
        chk("eg_together_dut1", 32'(g_dev[1].eg_split), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_read_sequencer.md
# rom_read_sequencer

- Synchronous read sequencer for one asynchronous EPROM (27128-class, 16K×8, active-low E/G) in the System86 simulation.
- Accepts address requests from a clocked consumer such as a tile or sprite fetch stage, and drives the EPROM's E, G and A pins with cycle-counted access and recovery windows sized to the part's tAVQV and tEHQZ/tGHQZ.
- Samples Q at the end of the access window and returns the byte with a one-cycle valid pulse.

## Interface

Parameters:
- ADDR_WIDTH, 14: EPROM address width.
- DATA_WIDTH, 8: EPROM data width.
- ACCESS_CYCLES, 13: clocks E/G are held low before Q is sampled. Must be ≥1. 13 × 20 ns ≥ 250 ns.
- RECOVERY_CYCLES, 3: clocks E/G are held high after sampling before the next access. May be 0. 3 × 20 ns ≥ 60 ns.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_ADDR  in  ADDR_WIDTH  request address.
- REQ_READY  out  1  request accepted this cycle when high together with REQ_VALID.
- RSP_VALID  out  1  one-cycle pulse; RSP_DATA valid.
- RSP_DATA  out  DATA_WIDTH  last byte read; held until the next capture.
- ROM_E  out  1  chip enable to EPROM, active low.
- ROM_G  out  1  output enable to EPROM, active low.
- ROM_A  out  ADDR_WIDTH  EPROM address.
- ROM_Q  in  DATA_WIDTH  EPROM data; may be X/Z outside the access window.

## Operation

States: IDLE, ACCESS, RECOVER. Down-counter CNT has width clog2(max(ACCESS_CYCLES, RECOVERY_CYCLES, 2)).

- IDLE:
  - REQ_READY = 1.
  - On REQ_VALID: ROM_A ← REQ_ADDR, ROM_E ← 0, ROM_G ← 0, CNT ← ACCESS_CYCLES−1, go to ACCESS.
- ACCESS:
  - REQ_READY = 0.
  - While CNT ≠ 0: decrement CNT.
  - When CNT = 0: RSP_DATA ← ROM_Q, RSP_VALID ← 1, ROM_E ← 1, ROM_G ← 1.
  - Then go to RECOVER with CNT ← RECOVERY_CYCLES−1, or to IDLE if RECOVERY_CYCLES = 0.
- RECOVER:
  - REQ_READY = 0.
  - Decrement CNT; go to IDLE when CNT = 0.
- Signal rules:
  - RSP_VALID is 1 only in the cycle after the capture edge; otherwise 0.
  - ROM_A changes only on an accepted request. It is held through ACCESS, RECOVER and IDLE (tAXQX = 0 is tolerated).
  - ROM_E and ROM_G always switch together on the same edge; there is no separate G-only phase.
  - REQ_ADDR is sampled only on the accept edge. Later changes during ACCESS have no effect.
  - No back-pressure on the response. The consumer must take RSP_DATA on the RSP_VALID cycle or read the held RSP_DATA later.
- Reset:
  - Asserting RST_n low, at any time including mid-ACCESS: state → IDLE, ROM_E = ROM_G = 1, ROM_A = 0, RSP_DATA = 0, RSP_VALID = 0, all immediately.
  - REQ_READY is forced 0 while RST_n is low.
  - An access aborted by reset produces no response.

## Timing

- Accept at rising edge k. ROM_E/ROM_G fall and ROM_A is valid after edge k.
- Capture at edge k+ACCESS_CYCLES. E/G low time = ACCESS_CYCLES clocks.
- RSP_VALID is high for the cycle between edges k+ACCESS_CYCLES and k+ACCESS_CYCLES+1.
- E/G high gap before the next access ≥ RECOVERY_CYCLES+1 clocks.
- Earliest next accept: edge k+ACCESS_CYCLES+RECOVERY_CYCLES+1. Sustained period = ACCESS_CYCLES+RECOVERY_CYCLES+1 clocks (17 at defaults).
- All outputs are registered except REQ_READY, which is decoded from state and RST_n.

## Structure

- Shared package system86_mem_pkg holds:
  - the state encoding constants (IDLE = 2'd0, ACCESS = 2'd1, RECOVER = 2'd2);
  - a clog2 constant function, reused by other memory-interface sequencers.
- No sub-module. A single always block handles the state/counter/datapath; REQ_READY is a continuous assign.
- Elaboration-time check: ACCESS_CYCLES < 1 → $error.

## Test plan

The bench uses a 20 ns clock and a 16K×8 EPROM behavioural model with 250 ns tAVQV/tELQV and 60 ns tEHQZ, loaded with pattern data[a] = a[7:0] ^ a[13:6]. Defaults are used unless a scenario states otherwise.

- **Reset values:** RST_n low → ROM_E = ROM_G = 1, ROM_A = 0, RSP_VALID = 0, RSP_DATA = 0, REQ_READY = 0. Release → REQ_READY = 1 on the next cycle.
- **Single read:** request 0x1234 → RSP_VALID exactly 13 clocks after the accept edge with RSP_DATA = pattern(0x1234). E/G low for exactly 260 ns, never X at capture.
- **Back-to-back:** 0x0000, 0x3FFF, 0x2AAA with REQ_VALID held high → accepts spaced 17 clocks apart, three correct responses in order, E/G high gap ≥ 80 ns between accesses.
- **Address stability:** toggle REQ_ADDR every cycle during ACCESS → ROM_A stays at the accepted value and the returned data matches the accepted address.
- **Reset mid-access:** assert RST_n at clock 6 of ACCESS → E/G go high within the same delta, no RSP_VALID follows, and a fresh request after release completes normally.
- **Zero-recovery config:** ACCESS_CYCLES = 13, RECOVERY_CYCLES = 0 → sustained period = 14 clocks, each response correct.
